// File: rtl/vga_rx_pkg.sv
// Shared constants, types and helpers for the VGA receive path.
package vga_rx_pkg;

  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_H_START     = 144;
  localparam int unsigned DEF_V_START     = 35;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_LOCK_FRAMES = 2;
  localparam bit          DEF_SYNC_NEG    = 1'b1;

  localparam int unsigned HCNT_W  = 11;
  localparam int unsigned VCNT_W  = 10;
  localparam int unsigned XY_W    = 10;
  localparam int unsigned RGB_W   = 3;
  localparam int unsigned MATCH_W = 8;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [HCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
  } totals_t;

  function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [VCNT_W-1:0] sat_inc_v(input logic [VCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_rx_sync_edge.sv
// Two-stage sync sampler: normalises polarity to active-high and flags the
// assertion edge (newest sample asserted, previous one not).
module vga_rx_sync_edge
  import vga_rx_pkg::*;
#(
  parameter bit SYNC_NEG = DEF_SYNC_NEG
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic edge_c
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sync_i ^ SYNC_NEG;
      s2_q <= s1_q;
    end
  end

  assign edge_c = s1_q & ~s2_q;

endmodule

// File: rtl/vga_rx.sv
// VGA stream receiver: recovers x/y of active pixels, measures line/frame
// totals and tracks lock against consecutive identical frames.
module vga_rx
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_START     = DEF_H_START,
  parameter int unsigned V_START     = DEF_V_START,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter bit          SYNC_NEG    = DEF_SYNC_NEG,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              r_in,
  input  logic              g_in,
  input  logic              b_in,
  output logic              pix_valid,
  output logic [XY_W-1:0]   x,
  output logic [XY_W-1:0]   y,
  output logic [RGB_W-1:0]  rgb,
  output logic              line_start,
  output logic              frame_start,
  output logic              locked,
  output logic [HCNT_W-1:0] h_total,
  output logic [VCNT_W-1:0] v_total,
  output logic              err
);

  localparam logic [HCNT_W-1:0] H_LO = HCNT_W'(H_START);
  localparam logic [HCNT_W-1:0] H_HI = HCNT_W'(H_START + H_ACTIVE);
  localparam logic [VCNT_W-1:0] V_LO = VCNT_W'(V_START);
  localparam logic [VCNT_W-1:0] V_HI = VCNT_W'(V_START + V_ACTIVE);

  logic h_edge_c, v_edge_c;

  vga_rx_sync_edge #(.SYNC_NEG(SYNC_NEG)) u_hsync (
    .clk(clk), .rst(rst), .sync_i(hsync_in), .edge_c(h_edge_c)
  );

  vga_rx_sync_edge #(.SYNC_NEG(SYNC_NEG)) u_vsync (
    .clk(clk), .rst(rst), .sync_i(vsync_in), .edge_c(v_edge_c)
  );

  lock_state_e         state_q, state_d;
  logic [RGB_W-1:0]    rgb_s1_q, rgb_s2_q;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d, h_len_c, h_meas_q, h_meas_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d, v_len_c, v_meas_q, v_meas_d;
  logic                timeout_c;
  totals_t             totals_c, ref_q, ref_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic                h_edge_q, v_edge_q;
  logic                lock_fault_c;

  logic                pix_valid_q, pix_valid_d;
  logic [XY_W-1:0]     x_q, x_d, y_q, y_d;
  logic [RGB_W-1:0]    rgb_q, rgb_d;
  logic                line_start_q, frame_start_q, locked_q, locked_d, err_q, err_d;
  logic [HCNT_W-1:0]   h_total_q;
  logic [VCNT_W-1:0]   v_total_q;

  // Counters and measurements; vsync clears vcnt even on a coincident hsync edge.
  always_comb begin
    h_len_c   = sat_inc_h(hcnt_q);
    v_len_c   = sat_inc_v(vcnt_q);
    hcnt_d    = h_edge_c ? '0 : h_len_c;
    timeout_c = (hcnt_d == '1);
    h_meas_d  = h_edge_c ? h_len_c : h_meas_q;
    v_meas_d  = v_edge_c ? v_len_c : v_meas_q;
    vcnt_d    = vcnt_q;
    if (v_edge_c) begin
      vcnt_d = '0;
    end else if (h_edge_c) begin
      vcnt_d = v_len_c;
    end
    totals_c.h = h_meas_d;
    totals_c.v = v_meas_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= SEARCH;
    else      state_q <= state_d;
  end

  // Next state; ref_q of zero means "no reference frame yet" (v_total is never 0 at a vsync edge).
  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    match_d      = match_q;
    lock_fault_c = (h_edge_c && (h_len_c != ref_q.h)) ||
                   (v_edge_c && (v_len_c != ref_q.v)) || timeout_c;
    case (state_q)
      SEARCH: begin
        if (v_edge_c) begin
          state_d = MEASURE;
          match_d = '0;
          ref_d   = '0;
        end
      end
      MEASURE: begin
        if (v_edge_c) begin
          ref_d = totals_c;
          if (totals_c == ref_q) begin
            match_d = match_q + 1'b1;
            if (int'(match_d) >= int'(LOCK_FRAMES) - 1) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (lock_fault_c) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Output stage: second pipeline step, coordinates hold outside the window.
  always_comb begin
    pix_valid_d = (state_q == LOCKED) &&
                  (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                  (vcnt_q >= V_LO) && (vcnt_q < V_HI);
    x_d         = pix_valid_d ? XY_W'(hcnt_q - H_LO) : x_q;
    y_d         = pix_valid_d ? XY_W'(vcnt_q - V_LO) : y_q;
    rgb_d       = pix_valid_d ? rgb_s2_q : rgb_q;
    locked_d    = (state_q == LOCKED);
    err_d       = locked_q && (state_q != LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_s1_q      <= '0;
      rgb_s2_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      ref_q         <= '0;
      match_q       <= '0;
      h_edge_q      <= 1'b0;
      v_edge_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      rgb_s1_q      <= {r_in, g_in, b_in};
      rgb_s2_q      <= rgb_s1_q;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      ref_q         <= ref_d;
      match_q       <= match_d;
      h_edge_q      <= h_edge_c;
      v_edge_q      <= v_edge_c;
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      line_start_q  <= h_edge_q;
      frame_start_q <= v_edge_q;
      locked_q      <= locked_d;
      h_total_q     <= h_meas_q;
      v_total_q     <= v_meas_q;
      err_q         <= err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx on a scaled-down timing (40x20 total, 24x12 active); a
// negative-sync and a positive-sync instance are both held to one reference model.
module tb_vga_rx;

  localparam int H_TOTAL = 40, HSW = 4, H_START = 8, H_ACTIVE = 24;
  localparam int V_TOTAL = 20, VSW = 2, V_START = 4, V_ACTIVE = 12;
  localparam int LOCK_FRAMES = 2;

  typedef struct packed {
    logic        pv;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  rgb;
    logic        ls;
    logic        fs;
    logic        lk;
    logic [10:0] ht;
    logic [9:0]  vt;
    logic        er;
  } out_t;

  logic clk = 1'b0;
  logic rst, hs, vs;
  logic [2:0] col;
  logic hs_n, vs_n;
  assign hs_n = ~hs;
  assign vs_n = ~vs;

  logic pv_n, ls_n, fs_n, lk_n, er_n, pv_p, ls_p, fs_p, lk_p, er_p;
  logic [9:0] x_n, y_n, vt_n, x_p, y_p, vt_p;
  logic [2:0] rgb_n, rgb_p;
  logic [10:0] ht_n, ht_p;
  out_t o_n, o_p;
  assign o_n = {pv_n, x_n, y_n, rgb_n, ls_n, fs_n, lk_n, ht_n, vt_n, er_n};
  assign o_p = {pv_p, x_p, y_p, rgb_p, ls_p, fs_p, lk_p, ht_p, vt_p, er_p};

  always #5 clk = ~clk;

  vga_rx #(.H_START(H_START), .V_START(V_START), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
           .SYNC_NEG(1'b1), .LOCK_FRAMES(LOCK_FRAMES)) u_dut_neg (
    .clk(clk), .rst(rst), .hsync_in(hs_n), .vsync_in(vs_n),
    .r_in(col[2]), .g_in(col[1]), .b_in(col[0]),
    .pix_valid(pv_n), .x(x_n), .y(y_n), .rgb(rgb_n), .line_start(ls_n),
    .frame_start(fs_n), .locked(lk_n), .h_total(ht_n), .v_total(vt_n), .err(er_n));

  vga_rx #(.H_START(H_START), .V_START(V_START), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
           .SYNC_NEG(1'b0), .LOCK_FRAMES(LOCK_FRAMES)) u_dut_pos (
    .clk(clk), .rst(rst), .hsync_in(hs), .vsync_in(vs),
    .r_in(col[2]), .g_in(col[1]), .b_in(col[0]),
    .pix_valid(pv_p), .x(x_p), .y(y_p), .rgb(rgb_p), .line_start(ls_p),
    .frame_start(fs_p), .locked(lk_p), .h_total(ht_p), .v_total(vt_p), .err(er_p));

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample-level view of the stream, results delayed two clocks via a queue.
  bit m_hp, m_vp, m_lock, m_meas, m_ref_ok;
  int m_pos, m_line, m_mh, m_mv, m_rh, m_rv, m_nmatch, m_x, m_y;
  logic [2:0] m_rgb;
  out_t exp_q[$];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    m_hp = 0; m_vp = 0; m_lock = 0; m_meas = 0; m_ref_ok = 0;
    m_pos = 0; m_line = 0; m_mh = 0; m_mv = 0; m_rh = 0; m_rv = 0; m_nmatch = 0;
    m_x = 0; m_y = 0; m_rgb = 3'd0;
  endfunction

  function automatic out_t model_step(input bit h, input bit v, input logic [2:0] c);
    out_t e;
    bit he, ve, was, win;
    he = h && !m_hp;
    ve = v && !m_vp;
    m_hp = h; m_vp = v;
    was = m_lock;
    if (he) begin m_mh = sat(m_pos + 1, 2047); m_pos = 0; end
    else m_pos = sat(m_pos + 1, 2047);
    if (ve) begin m_mv = sat(m_line + 1, 1023); m_line = 0; end
    else if (he) m_line = sat(m_line + 1, 1023);
    if (m_lock) begin
      if ((he && m_mh != m_rh) || (ve && m_mv != m_rv) || m_pos == 2047) m_lock = 0;
    end else if (ve) begin
      if (!m_meas) begin
        m_meas = 1; m_ref_ok = 0; m_nmatch = 0;
      end else begin
        if (m_ref_ok && m_mh == m_rh && m_mv == m_rv) begin
          m_nmatch++;
          if (m_nmatch >= LOCK_FRAMES - 1) begin m_lock = 1; m_meas = 0; end
        end else m_nmatch = 0;
        m_rh = m_mh; m_rv = m_mv; m_ref_ok = 1;
      end
    end
    win = m_lock && m_pos >= H_START && m_pos < H_START + H_ACTIVE &&
          m_line >= V_START && m_line < V_START + V_ACTIVE;
    if (win) begin m_x = m_pos - H_START; m_y = m_line - V_START; m_rgb = c; end
    e.pv = win; e.x = 10'(m_x); e.y = 10'(m_y); e.rgb = m_rgb;
    e.ls = he; e.fs = ve; e.lk = m_lock;
    e.ht = 11'(m_mh); e.vt = 10'(m_mv); e.er = was && !m_lock;
    return e;
  endfunction

  int err_cnt = 0, pv_cnt = 0, pv_last = 0, pv_total = 0;
  int fx = 0, fy = 0, lx = 0, ly = 0, fx_last = 0, fy_last = 0, lx_last = 0, ly_last = 0;

  task automatic tick(input logic h, input logic v, input logic [2:0] c, input logic r);
    out_t e;
    hs = h; vs = v; col = c; rst = r;
    @(posedge clk);
    #1;
    if (!r) begin
      e = '0;
      exp_q.delete();
      model_reset();
      exp_q.push_back('0);
      exp_q.push_back(model_step(1'b0, 1'b0, 3'd0));
    end else begin
      e = exp_q.pop_front();
      exp_q.push_back(model_step(h, v, c));
    end
    check("outs_negsync", 64'(o_n), 64'(e));
    check("outs_possync", 64'(o_p), 64'(e));
    if (er_n) err_cnt++;
    if (fs_n) begin
      pv_last = pv_cnt; pv_cnt = 0;
      fx_last = fx; fy_last = fy; lx_last = lx; ly_last = ly;
    end
    if (pv_n) begin
      if (pv_cnt == 0) begin fx = int'(x_n); fy = int'(y_n); end
      lx = int'(x_n); ly = int'(y_n);
      pv_cnt++; pv_total++;
    end
  endtask

  task automatic run_frame(input int bad_line, input int rst_line, input int rst_pix);
    for (int l = 0; l < V_TOTAL; l++) begin
      for (int p = 0; p < ((l == bad_line) ? H_TOTAL - 1 : H_TOTAL); p++)
        tick(p < HSW, l < VSW, 3'($urandom), !(l == rst_line && p == rst_pix));
    end
  endtask

  initial begin
    int e0, p0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 3'd0, 1'b0);
    check("reset_locked", 64'(lk_n), 64'd0);
    check("reset_h_total", 64'(ht_n), 64'd0);

    // Clean stream: lock at the start of frame 3
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    check("prelock_f2", 64'(lk_n), 64'd0);
    run_frame(-1, -1, -1);
    check("lock_f3", 64'(lk_n), 64'd1);
    check("h_total", 64'(ht_n), 64'(H_TOTAL));
    check("v_total", 64'(vt_n), 64'(V_TOTAL));
    run_frame(-1, -1, -1);
    check("pix_per_frame", 64'(pv_last), 64'(H_ACTIVE * V_ACTIVE));
    check("first_px", 64'({fx_last, fy_last}), 64'd0);
    check("last_px_x", 64'(lx_last), 64'(H_ACTIVE - 1));
    check("last_px_y", 64'(ly_last), 64'(V_ACTIVE - 1));

    // One short line while locked
    e0 = err_cnt;
    run_frame(int'($urandom_range(1, V_TOTAL - 2)), -1, -1);
    check("shortline_err", 64'(err_cnt - e0), 64'd1);
    check("shortline_unlock", 64'(lk_n), 64'd0);
    for (int i = 0; i < 4; i++) run_frame(-1, -1, -1);
    check("shortline_relock", 64'(lk_n), 64'd1);

    // Syncs stop: hcnt saturates and lock is lost
    e0 = err_cnt; p0 = pv_total;
    for (int i = 0; i < 2200; i++) tick(1'b0, 1'b0, 3'($urandom), 1'b1);
    check("timeout_err", 64'(err_cnt - e0), 64'd1);
    check("timeout_unlock", 64'(lk_n), 64'd0);
    check("timeout_no_pix", 64'(pv_total - p0), 64'd0);
    for (int i = 0; i < 4; i++) run_frame(-1, -1, -1);
    check("timeout_relock", 64'(lk_n), 64'd1);

    // One-cycle reset in mid-line
    e0 = err_cnt;
    run_frame(-1, int'($urandom_range(5, 15)), int'($urandom_range(0, H_TOTAL - 1)));
    check("reset_no_err", 64'(err_cnt - e0), 64'd0);
    check("reset_unlock", 64'(lk_n), 64'd0);
    for (int i = 0; i < 4; i++) run_frame(-1, -1, -1);
    check("reset_relock", 64'(lk_n), 64'd1);
    check("reset_pix_per_frame", 64'(pv_last), 64'(H_ACTIVE * V_ACTIVE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
